// File: rtl/bypass_network.sv
// EX-stage operand bypass network with a DEPTH-entry history of in-flight register writes.
// Forwards the youngest matching result to rs1/rs2, selects ALU A/B operands and raises a
// one-cycle load-use stall when the youngest producer is a load still in MEM.
// Optional macro BYPASS_STATS_EN adds saturating forward/stall event counters.
module bypass_network #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 3,
  parameter int unsigned RIDX  = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid_i,
  input  logic            ex_flush_i,
  input  logic            ex_regwr_i,
  input  logic            ex_is_load_i,
  input  logic [RIDX-1:0] ex_rd_i,
  input  logic [RIDX-1:0] ex_rs1_i,
  input  logic [RIDX-1:0] ex_rs2_i,
  input  logic [XLEN-1:0] ex_rdata1_i,
  input  logic [XLEN-1:0] ex_rdata2_i,
  input  logic [6:0]      ex_opcode_i,
  input  logic [XLEN-1:0] ex_pc_i,
  input  logic [XLEN-1:0] ex_imm_i,
  input  logic            ex_alusrc_i,
  input  logic [XLEN-1:0] alu_result_i,
  input  logic [XLEN-1:0] mem_rdata_i,
  output logic [XLEN-1:0] data1_o,
  output logic [XLEN-1:0] data2_o,
  output logic [XLEN-1:0] alu_a_o,
  output logic [XLEN-1:0] alu_b_o,
  output logic            stall_o
`ifdef BYPASS_STATS_EN
  ,
  output logic [31:0]     fwd_cnt_o,
  output logic [31:0]     stall_cnt_o
`endif
);

  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpSystem = 7'b1110011;

  typedef struct packed {
    logic            valid;
    logic            regwr;
    logic            is_load;
    logic [RIDX-1:0] rd;
    logic [XLEN-1:0] data;
    logic            ready;
  } slot_t;

  slot_t hist_q [DEPTH];
  slot_t hist_d [DEPTH];

  logic            hit1, hit2, rdy1, rdy2;
  logic [XLEN-1:0] fwd1, fwd2;

  function automatic logic slot_match(slot_t s, logic [RIDX-1:0] rs);
    return s.valid && s.regwr && (s.rd == rs) && (rs != '0);
  endfunction

  // Youngest-match lookup: scan oldest to youngest so the lowest slot index overrides.
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    rdy1 = 1'b1;
    rdy2 = 1'b1;
    fwd1 = ex_rdata1_i;
    fwd2 = ex_rdata2_i;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (slot_match(hist_q[k], ex_rs1_i)) begin
        hit1 = 1'b1;
        rdy1 = hist_q[k].ready;
        fwd1 = hist_q[k].data;
      end
      if (slot_match(hist_q[k], ex_rs2_i)) begin
        hit2 = 1'b1;
        rdy2 = hist_q[k].ready;
        fwd2 = hist_q[k].data;
      end
    end
  end

  // Only a load in slot 0 can be not-ready, so a stall always clears after one cycle.
  always_comb begin
    stall_o = ex_valid_i & ~ex_flush_i & ((hit1 & ~rdy1) | (hit2 & ~rdy2));
    data1_o = fwd1;
    data2_o = fwd2;
  end

  // ALU operand selection by opcode.
  always_comb begin
    alu_a_o = data1_o;
    alu_b_o = ex_alusrc_i ? ex_imm_i : data2_o;
    unique case (ex_opcode_i)
      OpAuipc: begin
        alu_a_o = ex_pc_i;
        alu_b_o = ex_imm_i;
      end
      OpJal, OpJalr: begin
        alu_a_o = ex_pc_i;
        alu_b_o = XLEN'(4);
      end
      OpLui: begin
        alu_a_o = '0;
        alu_b_o = ex_imm_i;
      end
      OpSystem: alu_b_o = '0;
      default: ;
    endcase
  end

  // History next state: EX (or a bubble) enters slot 0, slot 0 resolves load data into slot 1.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      hist_d[k] = '0;
    end
    if (!(ex_flush_i || stall_o)) begin
      hist_d[0].valid   = ex_valid_i;
      hist_d[0].regwr   = ex_regwr_i;
      hist_d[0].is_load = ex_is_load_i;
      hist_d[0].rd      = ex_rd_i;
      hist_d[0].data    = alu_result_i;
      hist_d[0].ready   = ~ex_is_load_i;
    end
    hist_d[1]       = hist_q[0];
    hist_d[1].data  = hist_q[0].is_load ? mem_rdata_i : hist_q[0].data;
    hist_d[1].ready = 1'b1;
    for (int k = 2; k < DEPTH; k++) begin
      hist_d[k] = hist_q[k-1];
    end
  end

  // History register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        hist_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        hist_q[k] <= hist_d[k];
      end
    end
  end

`ifdef BYPASS_STATS_EN
  logic [31:0] fwd_cnt_q, fwd_cnt_d, stall_cnt_q, stall_cnt_d;

  // Saturating event counters.
  always_comb begin
    fwd_cnt_d   = fwd_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if ((hit1 || hit2) && !stall_o && (fwd_cnt_q != 32'hFFFF_FFFF)) begin
      fwd_cnt_d = fwd_cnt_q + 32'd1;
    end
    if (stall_o && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      fwd_cnt_q   <= fwd_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fwd_cnt_o   = fwd_cnt_q;
  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_bypass_network.sv
// Directed self-checking bench for bypass_network (DEPTH = 3).
// Inputs are driven on the falling edge and outputs checked 1 ns later.
module tb_bypass_network;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid_i, ex_flush_i, ex_regwr_i, ex_is_load_i, ex_alusrc_i;
  logic [4:0]  ex_rd_i, ex_rs1_i, ex_rs2_i;
  logic [31:0] ex_rdata1_i, ex_rdata2_i, ex_pc_i, ex_imm_i, alu_result_i, mem_rdata_i;
  logic [6:0]  ex_opcode_i;
  logic [31:0] data1_o, data2_o, alu_a_o, alu_b_o;
  logic        stall_o;
`ifdef BYPASS_STATS_EN
  logic [31:0] fwd_cnt_o, stall_cnt_o;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [6:0] OpOp  = 7'b0110011;
  localparam logic [6:0] OpImm = 7'b0010011;

  always #5 clk = ~clk;

  bypass_network #(.XLEN(32), .DEPTH(3), .RIDX(5)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ex_valid_i   (ex_valid_i),
    .ex_flush_i   (ex_flush_i),
    .ex_regwr_i   (ex_regwr_i),
    .ex_is_load_i (ex_is_load_i),
    .ex_rd_i      (ex_rd_i),
    .ex_rs1_i     (ex_rs1_i),
    .ex_rs2_i     (ex_rs2_i),
    .ex_rdata1_i  (ex_rdata1_i),
    .ex_rdata2_i  (ex_rdata2_i),
    .ex_opcode_i  (ex_opcode_i),
    .ex_pc_i      (ex_pc_i),
    .ex_imm_i     (ex_imm_i),
    .ex_alusrc_i  (ex_alusrc_i),
    .alu_result_i (alu_result_i),
    .mem_rdata_i  (mem_rdata_i),
    .data1_o      (data1_o),
    .data2_o      (data2_o),
    .alu_a_o      (alu_a_o),
    .alu_b_o      (alu_b_o),
    .stall_o      (stall_o)
`ifdef BYPASS_STATS_EN
    ,
    .fwd_cnt_o    (fwd_cnt_o),
    .stall_cnt_o  (stall_cnt_o)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Set the EX instruction fields; operand/pc/imm fields keep their previous values.
  task automatic ex(input logic v, input logic fl, input logic wr, input logic ld,
                    input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                    input logic [31:0] alu);
    ex_valid_i   = v;
    ex_flush_i   = fl;
    ex_regwr_i   = wr;
    ex_is_load_i = ld;
    ex_rd_i      = rd;
    ex_rs1_i     = rs1;
    ex_rs2_i     = rs2;
    alu_result_i = alu;
  endtask

  initial begin
    rst_n = 1'b0;
    ex(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd5, 5'd6, 32'h0);
    ex_rdata1_i = 32'hA1; ex_rdata2_i = 32'hB2;
    ex_opcode_i = OpOp; ex_pc_i = 32'h0; ex_imm_i = 32'h0; ex_alusrc_i = 1'b0;
    mem_rdata_i = 32'h0;
    #1;
    check("rst_stall", {31'd0, stall_o}, 32'd0);
    check("rst_data1", data1_o, 32'hA1);
    check("rst_data2", data2_o, 32'hB2);
    check("rst_alu_b", alu_b_o, 32'hB2);

    @(negedge clk); rst_n = 1'b1;

    // ADD x5 = 0x11, then consumer of x5 forwards from slot 0.
    @(negedge clk);
    ex(1'b1, 1'b0, 1'b1, 1'b0, 5'd5, 5'd1, 5'd2, 32'h11);
    ex_rdata1_i = 32'h0; ex_rdata2_i = 32'h0;
    #1 check("add_prod_stall", {31'd0, stall_o}, 32'd0);
    @(negedge clk);
    ex(1'b1, 1'b0, 1'b1, 1'b0, 5'd9, 5'd5, 5'd2, 32'h22);
    ex_rdata1_i = 32'h999; ex_rdata2_i = 32'h222;
    #1;
    check("fwd_s0_alu_a", alu_a_o, 32'h11);
    check("fwd_s0_data2", data2_o, 32'h222);
    check("fwd_s0_stall", {31'd0, stall_o}, 32'd0);

    // LW x6 then consumer of x6: one stall cycle, then 0xCAFE from slot 1.
    @(negedge clk);
    ex(1'b1, 1'b0, 1'b1, 1'b1, 5'd6, 5'd0, 5'd0, 32'h1000);
    #1 check("lw_prod_stall", {31'd0, stall_o}, 32'd0);
    @(negedge clk);
    ex(1'b1, 1'b0, 1'b1, 1'b0, 5'd10, 5'd3, 5'd6, 32'hDEAD);
    ex_rdata1_i = 32'h3; ex_rdata2_i = 32'h0; mem_rdata_i = 32'hCAFE;
    #1 check("loaduse_stall", {31'd0, stall_o}, 32'd1);
    @(negedge clk);
    alu_result_i = 32'h33; mem_rdata_i = 32'h0;
    #1;
    check("loaduse_unstall", {31'd0, stall_o}, 32'd0);
    check("loaduse_alu_b", alu_b_o, 32'hCAFE);
    check("loaduse_data1", data1_o, 32'h3);

    // x7 written twice; youngest wins. x10 forwarded from the oldest slot.
    @(negedge clk);
    ex(1'b1, 1'b0, 1'b1, 1'b0, 5'd7, 5'd0, 5'd0, 32'h2);
    @(negedge clk);
    ex(1'b1, 1'b0, 1'b1, 1'b0, 5'd7, 5'd0, 5'd0, 32'h1);
    @(negedge clk);
    ex(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd7, 5'd10, 32'h0);
    ex_rdata1_i = 32'h77; ex_rdata2_i = 32'hAA;
    #1;
    check("youngest_data1", data1_o, 32'h1);
    check("oldest_slot_data2", data2_o, 32'h33);

    // x0 producer is never forwarded; x10 has now aged out of history.
    @(negedge clk);
    ex(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd10, 32'h55);
    ex_rdata1_i = 32'h0; ex_rdata2_i = 32'hAB;
    #1 check("aged_out_data2", data2_o, 32'hAB);
    @(negedge clk);
    ex(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0);
    ex_rdata1_i = 32'h0; ex_rdata2_i = 32'h12;
    #1;
    check("x0_data1", data1_o, 32'h0);
    check("x0_data2", data2_o, 32'h12);
    check("x0_stall", {31'd0, stall_o}, 32'd0);
    ex_opcode_i = 7'b1101111; ex_pc_i = 32'h100; ex_imm_i = 32'h7000;
    #1;
    check("jal_a", alu_a_o, 32'h100);
    check("jal_b", alu_b_o, 32'h4);
    ex_opcode_i = 7'b0110111;
    #1;
    check("lui_a", alu_a_o, 32'h0);
    check("lui_b", alu_b_o, 32'h7000);
    ex_opcode_i = 7'b0010111;
    #1 check("auipc_a", alu_a_o, 32'h100);
    ex_opcode_i = 7'b1110011;
    #1 check("system_b", alu_b_o, 32'h0);
    ex_opcode_i = OpImm; ex_alusrc_i = 1'b1;
    #1 check("opimm_b", alu_b_o, 32'h7000);
    ex_opcode_i = OpOp; ex_alusrc_i = 1'b0;

    // LW x8, then a flushed consumer that also claims to write x8: no stall, enters as bubble.
    @(negedge clk);
    ex(1'b1, 1'b0, 1'b1, 1'b1, 5'd8, 5'd0, 5'd0, 32'h2000);
    @(negedge clk);
    ex(1'b1, 1'b1, 1'b1, 1'b0, 5'd8, 5'd8, 5'd0, 32'hBAD);
    ex_rdata1_i = 32'h88; mem_rdata_i = 32'h8888;
    #1 check("flush_nostall", {31'd0, stall_o}, 32'd0);
    @(negedge clk);
    ex(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd8, 5'd0, 32'h0);
    mem_rdata_i = 32'h0;
    #1;
    check("flush_bubble_data1", data1_o, 32'h8888);
    check("flush_bubble_stall", {31'd0, stall_o}, 32'd0);

    // Invalid EX never stalls; then reset mid-stall clears stall at once.
    @(negedge clk);
    ex(1'b1, 1'b0, 1'b1, 1'b1, 5'd9, 5'd0, 5'd0, 32'h3000);
    @(negedge clk);
    ex(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd9, 5'd0, 32'h0);
    ex_rdata1_i = 32'h99;
    #1 check("invalid_nostall", {31'd0, stall_o}, 32'd0);
    ex_valid_i = 1'b1;
    #1 check("pre_rst_stall", {31'd0, stall_o}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_stall", {31'd0, stall_o}, 32'd0);
    check("rst_mid_data1", data1_o, 32'h99);
    @(negedge clk); rst_n = 1'b1;

    // Fresh history: 3 forwarding cycles (slots 0, 1, 2) and one stall.
    ex(1'b1, 1'b0, 1'b1, 1'b0, 5'd5, 5'd0, 5'd0, 32'h5);
    @(negedge clk);
    ex(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd5, 5'd0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    ex(1'b1, 1'b0, 1'b1, 1'b1, 5'd6, 5'd5, 5'd0, 32'h0);
    #1 check("fwd_s2_data1", data1_o, 32'h5);
    @(negedge clk);
    ex(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd6, 32'h0);
    mem_rdata_i = 32'h66;
    #1 check("stats_stall", {31'd0, stall_o}, 32'd1);
    @(negedge clk);
    ex(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0);
    #1;
`ifdef BYPASS_STATS_EN
    check("fwd_cnt", fwd_cnt_o, 32'd3);
    check("stall_cnt", stall_cnt_o, 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
